// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and op-classification helpers.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_MADD  = 3'd2;
   localparam logic [2:0] OP_MADDU = 3'd3;
   localparam logic [2:0] OP_MSUB  = 3'd4;
   localparam logic [2:0] OP_MSUBU = 3'd5;
   localparam logic [2:0] OP_DIV   = 3'd6;
   localparam logic [2:0] OP_DIVU  = 3'd7;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   // Even encodings are the signed variants.
   function automatic logic is_signed(input logic [2:0] op);
      return !op[0];
   endfunction

   function automatic logic is_acc(input logic [2:0] op);
      return (op >= OP_MADD) && (op <= OP_MSUBU);
   endfunction

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide loop (combinational).
// Multiply: add operand into the high half when lo[0] is set, then shift right.
// Divide (only with EX_MULDIV_DIV_EN): shift {hi,lo} left by one, trial-subtract
// the divisor from the partial remainder and restore when it would go negative.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
`ifdef EX_MULDIV_DIV_EN
   input  logic             div_mode,
`endif
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   logic [WIDTH:0] sum;
`ifdef EX_MULDIV_DIV_EN
   logic [WIDTH:0] shifted;
   logic           fits;
`endif

   // Select shift-add or trial-subtract for this iteration.
   always_comb begin
      sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
`ifdef EX_MULDIV_DIV_EN
      shifted = {hi_in, lo_in[WIDTH-1]};
      fits    = shifted >= {1'b0, operand};
      if (div_mode) begin
         // When the divisor fits, the difference is below the divisor, so W bits suffice.
         hi_out = fits ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
         lo_out = {lo_in[WIDTH-2:0], fits};
      end
`endif
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit with HI/LO accumulate.
// Runs WIDTH shift-add / restoring-divide iterations on operand magnitudes,
// then a fix-up cycle applies sign correction and accumulation.
// Build option: define EX_MULDIV_DIV_EN to include the divider (ops DIV/DIVU);
// without it those ops are rejected and div_by_zero is tied low.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_by_zero
);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic               sign_a_q;
   logic               sign_b_q;
   logic [WIDTH-1:0]   operand_q;
   logic [WIDTH-1:0]   prod_hi_q;
   logic [WIDTH-1:0]   prod_lo_q;
   logic [WIDTH-1:0]   acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;
`ifdef EX_MULDIV_DIV_EN
   logic               dz_q;
`endif

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               op_legal;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic               res_neg;
   logic [2*WIDTH-1:0] prod_sgn;
   logic [2*WIDTH-1:0] full;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign busy = (state_q != IDLE);

   // Operand magnitudes and op legality for the start handshake.
   always_comb begin
      a_neg = is_signed(op) && src_a[WIDTH-1];
      b_neg = is_signed(op) && src_b[WIDTH-1];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;
`ifdef EX_MULDIV_DIV_EN
      op_legal = 1'b1;
`else
      op_legal = !is_div(op);
`endif
   end

`ifdef EX_MULDIV_DIV_EN
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div(op_q)),
      .hi_in    (prod_hi_q),
      .lo_in    (prod_lo_q),
      .operand  (operand_q),
      .hi_out   (step_hi),
      .lo_out   (step_lo)
   );
`else
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .hi_in    (prod_hi_q),
      .lo_in    (prod_lo_q),
      .operand  (operand_q),
      .hi_out   (step_hi),
      .lo_out   (step_lo)
   );
`endif

   // Fix-up: sign-correct the magnitude result and apply HI/LO accumulation.
   always_comb begin
      res_neg  = is_signed(op_q) && (sign_a_q != sign_b_q);
      prod_sgn = res_neg ? -{prod_hi_q, prod_lo_q} : {prod_hi_q, prod_lo_q};
      if (is_acc(op_q)) begin
         full = is_sub(op_q) ? ({acc_hi_q, acc_lo_q} - prod_sgn)
                             : ({acc_hi_q, acc_lo_q} + prod_sgn);
      end else begin
         full = prod_sgn;
      end
      fix_hi = full[2*WIDTH-1:WIDTH];
      fix_lo = full[WIDTH-1:0];
`ifdef EX_MULDIV_DIV_EN
      if (is_div(op_q)) begin
         if (dz_q) begin
            fix_hi = prod_hi_q;
            fix_lo = '1;
         end else begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            fix_lo = res_neg ? -prod_lo_q : prod_lo_q;
            fix_hi = (is_signed(op_q) && sign_a_q) ? -prod_hi_q : prod_hi_q;
         end
      end
`endif
   end

`ifndef EX_MULDIV_DIV_EN
   assign div_by_zero = 1'b0;
`endif

   // Control FSM, iteration counter and registered results.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         operand_q <= '0;
         prod_hi_q <= '0;
         prod_lo_q <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         done      <= 1'b0;
         res_hi    <= '0;
         res_lo    <= '0;
`ifdef EX_MULDIV_DIV_EN
         dz_q        <= 1'b0;
         div_by_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && op_legal) begin
                     op_q      <= op;
                     sign_a_q  <= a_neg;
                     sign_b_q  <= b_neg;
                     acc_hi_q  <= acc_hi;
                     acc_lo_q  <= acc_lo;
                     cnt_q     <= '0;
                     prod_hi_q <= '0;
                     prod_lo_q <= b_mag;
                     operand_q <= a_mag;
                     state_q   <= CALC;
`ifdef EX_MULDIV_DIV_EN
                     dz_q <= 1'b0;
                     if (is_div(op)) begin
                        prod_lo_q <= a_mag;
                        operand_q <= b_mag;
                        if (src_b == '0) begin
                           // Skip the loop; the raw dividend is returned in HI.
                           dz_q      <= 1'b1;
                           prod_hi_q <= src_a;
                           state_q   <= FIX;
                        end
                     end
`endif
                  end
               end
               CALC: begin
                  prod_hi_q <= step_hi;
                  prod_lo_q <= step_lo;
                  cnt_q     <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     state_q <= FIX;
                  end
               end
               FIX: begin
                  res_hi  <= fix_hi;
                  res_lo  <= fix_lo;
                  done    <= 1'b1;
                  state_q <= IDLE;
`ifdef EX_MULDIV_DIV_EN
                  div_by_zero <= dz_q;
`endif
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32): directed cases, randomized ops
// against a 64-bit arithmetic reference model, flush, busy-start, back-to-back
// and mid-operation reset.
module tb_ex_muldiv;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [31:0] acc_hi = '0;
   logic [31:0] acc_lo = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        div_by_zero;

   int total = 0;
   int bad = 0;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .acc_hi      (acc_hi),
      .acc_lo      (acc_lo),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, b, ah, al,
                                 output logic [31:0] mh, ml, output logic mdz);
      longint sa, sb, p, q, r;
      logic [63:0] acc, res;
      logic sgn;
      sgn = (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_DIV);
      sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      mdz = 1'b0;
      if (o == OP_DIV || o == OP_DIVU) begin
         if (b == 0) begin
            mh = a; ml = 32'hFFFF_FFFF; mdz = 1'b1;
         end else begin
            q = sa / sb; r = sa % sb;
            mh = r[31:0]; ml = q[31:0];
         end
      end else begin
         p   = sa * sb;
         acc = {ah, al};
         if (o == OP_MADD || o == OP_MADDU)      res = acc + p;
         else if (o == OP_MSUB || o == OP_MSUBU) res = acc - p;
         else                                    res = p;
         mh = res[63:32]; ml = res[31:0];
      end
   endfunction

   // Issue one op from a negedge and wait (bounded) for done; returns at the done negedge.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, ah, al,
                         output int lat, output int bcnt,
                         output logic [31:0] rh, rl, output logic rdz);
      op = o; src_a = a; src_b = b; acc_hi = ah; acc_lo = al; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = -1; bcnt = 0; rh = 'x; rl = 'x; rdz = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         if (done) begin
            lat = k - 1; rh = res_hi; rl = res_lo; rdz = div_by_zero;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (res_hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", res_hi); end
      total++; if (res_lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", res_lo); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int lat, bcnt;
      logic [31:0] rh, rl;
      logic rdz;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
      total++; if (bcnt !== 33) begin bad++; $display("FAIL mult_busy: got %0d want 33", bcnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_in_done: got %b want 0", busy); end
      total++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         bad++; $display("FAIL mult_res: got %h_%h want ffffffff_ffffffeb", rh, rl); end
      run_op(OP_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'h1_0000_0000) begin
         bad++; $display("FAIL maddu_res: got %h_%h want 00000001_00000000", rh, rl); end
      run_op(OP_MSUB, 32'h2, 32'h3, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         bad++; $display("FAIL msub_res: got %h_%h want ffffffff_fffffffa", rh, rl); end
`ifdef EX_MULDIV_DIV_EN
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         bad++; $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", rh, rl); end
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'h0000_0000_8000_0000) begin
         bad++; $display("FAIL div_minneg: got %h_%h want 00000000_80000000", rh, rl); end
      run_op(OP_DIVU, 32'h7, 32'h0, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
      total++; if (rdz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", rdz); end
      total++; if ({rh, rl} !== 64'h0000_0007_FFFF_FFFF) begin
         bad++; $display("FAIL dz_res: got %h_%h want 00000007_ffffffff", rh, rl); end
`else
      begin
         logic saw_busy, saw_done;
         saw_busy = 1'b0; saw_done = 1'b0;
         op = OP_DIVU; src_a = 32'h7; src_b = 32'h0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
            @(negedge clk);
         end
         total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL nodiv_busy: got %b want 0", saw_busy); end
         total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL nodiv_done: got %b want 0", saw_done); end
         total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL nodiv_dz: got %b want 0", div_by_zero); end
      end
`endif
   endtask

   task automatic test_random();
      int lat, bcnt;
      logic [31:0] rh, rl, mh, ml, a, b, ah, al;
      logic rdz, mdz;
      logic [2:0] o;
      logic [31:0] corner [5];
      corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
      for (int i = 0; i < 30; i++) begin
`ifdef EX_MULDIV_DIV_EN
         o = 3'($urandom_range(0, 7));
`else
         o = 3'($urandom_range(0, 5));
`endif
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         ah = $urandom; al = $urandom;
         model(o, a, b, ah, al, mh, ml, mdz);
         run_op(o, a, b, ah, al, lat, bcnt, rh, rl, rdz);
         total++; if ({rh, rl} !== {mh, ml}) begin
            bad++; $display("FAIL rand_res op=%0d a=%h b=%h: got %h_%h want %h_%h",
                            o, a, b, rh, rl, mh, ml); end
         total++; if (lat !== (mdz ? 1 : 33)) begin
            bad++; $display("FAIL rand_latency op=%0d: got %0d want %0d", o, lat, mdz ? 1 : 33); end
`ifdef EX_MULDIV_DIV_EN
         total++; if (rdz !== mdz) begin
            bad++; $display("FAIL rand_dz op=%0d: got %b want %b", o, rdz, mdz); end
`endif
      end
   endtask

   task automatic test_flush();
      int lat, bcnt;
      logic [31:0] rh, rl, old_hi, old_lo;
      logic rdz;
      old_hi = res_hi; old_lo = res_lo;
      op = OP_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b want 0", done); end
      total++; if ({res_hi, res_lo} !== {old_hi, old_lo}) begin
         bad++; $display("FAIL flush_res: got %h_%h want %h_%h", res_hi, res_lo, old_hi, old_lo); end
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if (lat !== 33) begin bad++; $display("FAIL flush_restart_latency: got %0d want 33", lat); end
      total++; if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
         bad++; $display("FAIL flush_restart_res: got %h_%h want fffffffe_00000001", rh, rl); end
   endtask

   task automatic test_start_while_busy();
      int dones;
      logic [31:0] rh, rl;
      dones = 0; rh = 'x; rl = 'x;
      op = OP_MULT; src_a = 32'd100; src_b = 32'hFFFF_FFFE; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         if (k == 5) begin
            op = OP_MULTU; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dones++;
            if (dones == 1) begin rh = res_hi; rl = res_lo; end
         end
         @(negedge clk);
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
      total++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FF38) begin
         bad++; $display("FAIL busy_start_res: got %h_%h want ffffffff_ffffff38", rh, rl); end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      logic [31:0] rh, rl, mh, ml;
      logic rdz, mdz;
      run_op(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'd42) begin bad++; $display("FAIL b2b_first: got %h_%h want 0_2a", rh, rl); end
      // Now at the done negedge: issue the next op in the done cycle.
      model(OP_MSUBU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444, mh, ml, mdz);
      run_op(OP_MSUBU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444,
             lat, bcnt, rh, rl, rdz);
      total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
      total++; if ({rh, rl} !== {mh, ml}) begin
         bad++; $display("FAIL b2b_second: got %h_%h want %h_%h", rh, rl, mh, ml); end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      logic [31:0] rh, rl;
      logic rdz;
      op = OP_MULT; src_a = 32'h5555_5555; src_b = 32'h3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      total++; if ({res_hi, res_lo} !== 64'h0) begin
         bad++; $display("FAIL rst_mid_res: got %h_%h want 0_0", res_hi, res_lo); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy: got %b want 0", busy); end
      run_op(OP_MADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h5, lat, bcnt, rh, rl, rdz);
      total++; if ({rh, rl} !== 64'h3) begin bad++; $display("FAIL rst_after_op: got %h_%h want 0_3", rh, rl); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
